// File: rtl/wrapper_keypad_ctrl_if.sv
// rtl/wrapper_keypad_ctrl_if.sv - key/vsync inputs and debounced key event outputs of the keypad controller
interface wrapper_keypad_ctrl_if #(
   parameter int NKEYS = 4
);
   logic [NKEYS-1:0] keys;
   logic             vsync;
   logic [NKEYS-1:0] key_level;
   logic [NKEYS-1:0] key_press;
   logic [NKEYS-1:0] key_release;
   logic [NKEYS-1:0] key_frame;
   logic [NKEYS-1:0] key_rep;
   logic             frame_tick;

   modport master (
      output keys, vsync,
      input  key_level, key_press, key_release, key_frame, key_rep, frame_tick
   );

   modport slave (
      input  keys, vsync,
      output key_level, key_press, key_release, key_frame, key_rep, frame_tick
   );
endinterface

// File: rtl/wrapper_keypad_ctrl.sv
// rtl/wrapper_keypad_ctrl.sv - keypad debouncer with edge pulses, per-frame latch and frame-based auto-repeat
module wrapper_keypad_ctrl #(
   parameter int NKEYS         = 4,
   parameter int DB_TICKS      = 50000,
   parameter int KEY_ACT_LOW   = 0,
   parameter int VSYNC_ACT_LOW = 1,
   parameter int REPEAT_DELAY  = 30,
   parameter int REPEAT_RATE   = 6
) (
   input  logic                  clk,
   input  logic                  reset,
   wrapper_keypad_ctrl_if.slave  kp
);
   typedef enum logic [1:0] {RPT_IDLE, RPT_DELAY, RPT_REPEAT} rpt_state_e;

   localparam logic [15:0]      DB_MAX   = 16'(DB_TICKS - 1);
   localparam logic [7:0]       DELAY_FR = 8'(REPEAT_DELAY);
   localparam logic [7:0]       RATE_FR  = 8'(REPEAT_RATE);
   localparam logic [NKEYS-1:0] KEY_POL  = (KEY_ACT_LOW != 0) ? {NKEYS{1'b1}} : {NKEYS{1'b0}};
   localparam logic             VS_POL   = (VSYNC_ACT_LOW != 0);

   logic [NKEYS-1:0] ksync1_q, ksync1_d, ksync2_q, ksync2_d;
   logic             vsync1_q, vsync1_d, vsync2_q, vsync2_d;
   logic             vact_prev_q, vact_prev_d;
   logic [NKEYS-1:0] stable_q, stable_d;
   logic [15:0]      db_cnt_q [NKEYS];
   logic [15:0]      db_cnt_d [NKEYS];
   rpt_state_e       rpt_state_q [NKEYS];
   rpt_state_e       rpt_state_d [NKEYS];
   logic [7:0]       rpt_cnt_q [NKEYS];
   logic [7:0]       rpt_cnt_d [NKEYS];
   logic [NKEYS-1:0] key_level_q, key_level_d;
   logic [NKEYS-1:0] key_press_q, key_press_d;
   logic [NKEYS-1:0] key_release_q, key_release_d;
   logic [NKEYS-1:0] key_frame_q, key_frame_d;
   logic [NKEYS-1:0] key_rep_q, key_rep_d;
   logic             frame_tick_q, frame_tick_d;

   logic [NKEYS-1:0] key_norm;
   logic             vact;
   logic [7:0]       rpt_cnt_inc;

   always_comb begin
      key_norm      = ksync2_q ^ KEY_POL;
      vact          = vsync2_q ^ VS_POL;
      rpt_cnt_inc   = '0;

      ksync1_d      = kp.keys;
      ksync2_d      = ksync1_q;
      vsync1_d      = kp.vsync;
      vsync2_d      = vsync1_q;
      vact_prev_d   = vact;

      frame_tick_d  = vact & ~vact_prev_q;
      key_level_d   = stable_q;
      key_press_d   = stable_q & ~key_level_q;
      key_release_d = ~stable_q & key_level_q;
      key_frame_d   = frame_tick_q ? key_level_q : key_frame_q;

      stable_d      = stable_q;
      key_rep_d     = '0;

      for (int i = 0; i < NKEYS; i++) begin
         db_cnt_d[i] = '0;
         if (key_norm[i] != stable_q[i]) begin
            if (db_cnt_q[i] == DB_MAX) begin
               stable_d[i] = key_norm[i];
            end else begin
               db_cnt_d[i] = db_cnt_q[i] + 16'd1;
            end
         end
      end

      // Release wins over a same-cycle frame tick; a tick arriving with the press is not counted.
      for (int i = 0; i < NKEYS; i++) begin
         rpt_state_d[i] = rpt_state_q[i];
         rpt_cnt_d[i]   = rpt_cnt_q[i];
         rpt_cnt_inc    = rpt_cnt_q[i] + 8'd1;
         if (key_release_d[i]) begin
            rpt_state_d[i] = RPT_IDLE;
            rpt_cnt_d[i]   = '0;
         end else begin
            case (rpt_state_q[i])
               RPT_IDLE: begin
                  if (key_press_d[i]) begin
                     rpt_state_d[i] = RPT_DELAY;
                     rpt_cnt_d[i]   = '0;
                     key_rep_d[i]   = 1'b1;
                  end
               end
               RPT_DELAY: begin
                  if (frame_tick_d) begin
                     if (rpt_cnt_inc == DELAY_FR) begin
                        rpt_state_d[i] = RPT_REPEAT;
                        rpt_cnt_d[i]   = '0;
                        key_rep_d[i]   = 1'b1;
                     end else begin
                        rpt_cnt_d[i]   = rpt_cnt_inc;
                     end
                  end
               end
               RPT_REPEAT: begin
                  if (frame_tick_d) begin
                     if (rpt_cnt_inc == RATE_FR) begin
                        rpt_cnt_d[i] = '0;
                        key_rep_d[i] = 1'b1;
                     end else begin
                        rpt_cnt_d[i] = rpt_cnt_inc;
                     end
                  end
               end
               default: begin
                  rpt_state_d[i] = RPT_IDLE;
                  rpt_cnt_d[i]   = '0;
               end
            endcase
         end
      end
   end

   // Previous vsync level resets to active so the cleared synchroniser cannot fake a frame edge.
   always_ff @(posedge clk) begin
      if (reset) begin
         ksync1_q      <= '0;
         ksync2_q      <= '0;
         vsync1_q      <= 1'b0;
         vsync2_q      <= 1'b0;
         vact_prev_q   <= 1'b1;
         stable_q      <= '0;
         key_level_q   <= '0;
         key_press_q   <= '0;
         key_release_q <= '0;
         key_frame_q   <= '0;
         key_rep_q     <= '0;
         frame_tick_q  <= 1'b0;
         for (int i = 0; i < NKEYS; i++) begin
            db_cnt_q[i]    <= '0;
            rpt_state_q[i] <= RPT_IDLE;
            rpt_cnt_q[i]   <= '0;
         end
      end else begin
         ksync1_q      <= ksync1_d;
         ksync2_q      <= ksync2_d;
         vsync1_q      <= vsync1_d;
         vsync2_q      <= vsync2_d;
         vact_prev_q   <= vact_prev_d;
         stable_q      <= stable_d;
         key_level_q   <= key_level_d;
         key_press_q   <= key_press_d;
         key_release_q <= key_release_d;
         key_frame_q   <= key_frame_d;
         key_rep_q     <= key_rep_d;
         frame_tick_q  <= frame_tick_d;
         for (int i = 0; i < NKEYS; i++) begin
            db_cnt_q[i]    <= db_cnt_d[i];
            rpt_state_q[i] <= rpt_state_d[i];
            rpt_cnt_q[i]   <= rpt_cnt_d[i];
         end
      end
   end

   assign kp.key_level   = key_level_q;
   assign kp.key_press   = key_press_q;
   assign kp.key_release = key_release_q;
   assign kp.key_frame   = key_frame_q;
   assign kp.key_rep     = key_rep_q;
   assign kp.frame_tick  = frame_tick_q;
endmodule

// File: tb/tb_wrapper_keypad_ctrl.sv
// tb/tb_wrapper_keypad_ctrl.sv - directed and randomized bench for wrapper_keypad_ctrl against a frame-level reference model
module tb_wrapper_keypad_ctrl;
   localparam int NK = 4;
   localparam int DB = 4;
   localparam int RD = 3;
   localparam int RR = 2;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic          reset;
   logic [NK-1:0] keys;
   logic          vsync;

   wrapper_keypad_ctrl_if #(.NKEYS(NK)) kif ();
   assign kif.keys  = keys;
   assign kif.vsync = vsync;

   wrapper_keypad_ctrl #(
      .NKEYS(NK), .DB_TICKS(DB), .KEY_ACT_LOW(0), .VSYNC_ACT_LOW(1),
      .REPEAT_DELAY(RD), .REPEAT_RATE(RR)
   ) dut (
      .clk   (clk),
      .reset (reset),
      .kp    (kif.slave)
   );

   int n_checks = 0;
   int n_err    = 0;

   // reference model state
   logic [NK-1:0] m_k1, m_k2, m_stable, m_level, m_press, m_rel, m_frame, m_rep;
   logic          m_v1, m_v2, m_vprev, m_tick;
   int            m_run    [NK];
   int            m_frames [NK];
   bit            m_held   [NK];

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
      end
   endtask

   task automatic model_step();
      logic [NK-1:0] nl, np, nr, nf, ns, nrep;
      logic          nt;
      if (reset) begin
         m_k1 = '0; m_k2 = '0; m_stable = '0; m_level = '0; m_press = '0;
         m_rel = '0; m_frame = '0; m_rep = '0; m_tick = 1'b0;
         m_v1 = 1'b1; m_v2 = 1'b1; m_vprev = 1'b1;
         for (int i = 0; i < NK; i++) begin
            m_run[i] = 0; m_frames[i] = 0; m_held[i] = 1'b0;
         end
      end else begin
         nl = m_stable;
         np = m_stable & ~m_level;
         nr = ~m_stable & m_level;
         nt = m_v2 & ~m_vprev;
         nf = m_tick ? m_level : m_frame;
         ns = m_stable;
         for (int i = 0; i < NK; i++) begin
            if (m_k2[i] !== m_stable[i]) begin
               m_run[i]++;
               if (m_run[i] == DB) begin
                  ns[i] = m_k2[i];
                  m_run[i] = 0;
               end
            end else begin
               m_run[i] = 0;
            end
         end
         nrep = '0;
         for (int i = 0; i < NK; i++) begin
            if (np[i]) begin
               m_held[i] = 1'b1; m_frames[i] = 0; nrep[i] = 1'b1;
            end else if (nr[i]) begin
               m_held[i] = 1'b0; m_frames[i] = 0;
            end else if (m_held[i] && nt) begin
               m_frames[i]++;
               if (m_frames[i] == RD || (m_frames[i] > RD && (m_frames[i] - RD) % RR == 0))
                  nrep[i] = 1'b1;
            end
         end
         m_vprev = m_v2; m_v2 = m_v1; m_v1 = ~vsync;
         m_k2 = m_k1; m_k1 = keys;
         m_stable = ns; m_level = nl; m_press = np; m_rel = nr;
         m_tick = nt; m_frame = nf; m_rep = nrep;
      end
   endtask

   task automatic cyc();
      @(posedge clk);
      model_step();
      #1;
      check("level",   32'(kif.key_level),   32'(m_level));
      check("press",   32'(kif.key_press),   32'(m_press));
      check("release", 32'(kif.key_release), 32'(m_rel));
      check("frame",   32'(kif.key_frame),   32'(m_frame));
      check("rep",     32'(kif.key_rep),     32'(m_rep));
      check("tick",    32'(kif.frame_tick),  32'(m_tick));
   endtask

   int first, cnt, reps, ticks, mask, hit, seen, vph, vper;
   int kleft [NK];

   initial begin
      reset = 1'b1; keys = '0; vsync = 1'b1;
      repeat (3) cyc();
      check("rst_outs", 32'({kif.key_level, kif.key_press, kif.key_release,
                             kif.key_frame, kif.key_rep, kif.frame_tick}), 32'd0);
      reset = 1'b0;
      repeat (5) cyc();

      // debounce latency and single press
      keys = 4'b0001; first = -1; cnt = 0;
      for (int c = 0; c < 10; c++) begin
         cyc();
         if (kif.key_press[0]) begin cnt++; if (first < 0) first = c; end
      end
      check("db_latency", 32'(first), 32'(DB + 2));
      check("db_npress", 32'(cnt), 32'd1);
      check("db_level", 32'(kif.key_level), 32'b0001);

      // glitch shorter than DB
      keys = 4'b0011; seen = 0;
      for (int c = 0; c < 15; c++) begin
         if (c == 3) keys = 4'b0001;
         cyc();
         seen |= int'(kif.key_level[1] | kif.key_press[1] | kif.key_release[1]);
      end
      check("glitch", 32'(seen), 32'd0);

      // frame latch
      keys = 4'b0101;
      repeat (10) cyc();
      vsync = 1'b0; ticks = 0;
      for (int c = 0; c < 12; c++) begin
         if (c == 2) vsync = 1'b1;
         cyc();
         ticks += int'(kif.frame_tick);
      end
      check("frame_ticks", 32'(ticks), 32'd1);
      check("frame_val", 32'(kif.key_frame), 32'b0101);
      keys = 4'b0000;
      repeat (12) cyc();
      check("frame_hold", 32'(kif.key_frame), 32'b0101);

      // auto-repeat over 10 frames
      keys = 4'b0001; reps = 0; ticks = 0; mask = 0;
      repeat (8) begin cyc(); reps += int'(kif.key_rep[0]); end
      for (int f = 1; f <= 10; f++) begin
         for (int c = 0; c < 8; c++) begin
            vsync = (c < 2) ? 1'b0 : 1'b1;
            cyc();
            if (kif.frame_tick) ticks++;
            if (kif.key_rep[0]) begin
               reps++;
               if (kif.frame_tick) mask |= (1 << ticks);
            end
         end
      end
      check("rep_count", 32'(reps), 32'd5);
      check("rep_mask", 32'(mask), 32'((1 << 3) | (1 << 5) | (1 << 7) | (1 << 9)));
      check("rep_ticks", 32'(ticks), 32'd10);

      // release coinciding with frame tick
      keys = 4'b0000;
      repeat (4) cyc();
      vsync = 1'b0; hit = 0;
      for (int c = 0; c < 10; c++) begin
         if (c == 2) vsync = 1'b1;
         cyc();
         if (kif.key_release[0]) begin
            hit++;
            check("relpri_tick", 32'(kif.frame_tick), 32'd1);
            check("relpri_rep", 32'(kif.key_rep[0]), 32'd0);
         end
      end
      check("relpri_seen", 32'(hit), 32'd1);
      keys = 4'b0001; reps = 0;
      repeat (16) begin cyc(); reps += int'(kif.key_rep[0]); end
      check("idle_repress", 32'(reps), 32'd1);

      // reset in the middle of REPEAT with key held
      for (int f = 0; f < 5; f++) begin
         for (int c = 0; c < 8; c++) begin
            vsync = (c < 2) ? 1'b0 : 1'b1;
            cyc();
         end
      end
      reset = 1'b1; seen = 0;
      repeat (3) begin
         cyc();
         seen |= int'(|{kif.key_level, kif.key_press, kif.key_release,
                        kif.key_frame, kif.key_rep, kif.frame_tick});
      end
      check("rst_mid_zero", 32'(seen), 32'd0);
      reset = 1'b0; first = -1; cnt = 0; reps = 0;
      for (int c = 0; c < 12; c++) begin
         cyc();
         if (kif.key_press[0]) begin cnt++; if (first < 0) first = c; end
         reps += int'(kif.key_rep[0]);
      end
      check("rst_press_lat", 32'(first), 32'(DB + 2));
      check("rst_npress", 32'(cnt), 32'd1);
      check("rst_nrep", 32'(reps), 32'd1);

      // randomized traffic
      for (int i = 0; i < NK; i++) kleft[i] = $urandom_range(1, 40);
      vph = 0; vper = 10;
      for (int c = 0; c < 3000; c++) begin
         for (int i = 0; i < NK; i++) begin
            if (kleft[i] == 0) begin
               keys[i] = ~keys[i];
               kleft[i] = ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, 3))
                                                      : int'($urandom_range(5, 120));
            end else begin
               kleft[i]--;
            end
         end
         vsync = (vph < 2) ? 1'b0 : 1'b1;
         vph++;
         if (vph >= vper) begin vph = 0; vper = $urandom_range(6, 16); end
         reset = ($urandom_range(0, 599) == 0) ? 1'b1 : (reset && ($urandom_range(0, 1) == 1));
         cyc();
      end
      reset = 1'b0;
      repeat (4) cyc();

      $display("Result: errors=%0d of %0d checks", n_err, n_checks);
      $finish;
   end
endmodule
